rot_seq: RTL and testbench
==========================

ROT_SEQ -- requirements
Module: rot_seq

Interface
REQ-001 Parameter TILE_LOG2, default 2, log2 of the square tile edge in pixels (4x4 tiles).
REQ-002 Parameter DIM_W, default 16, width of the image dimension inputs.
REQ-003 I_SEQ_HCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 I_SEQ_HRESET_N  input  1  hard reset; asynchronous, active-low.
REQ-005 I_SEQ_RESET  input  1  soft reset from the register file; synchronous, active-high.
REQ-006 I_SEQ_START  input  1  job start level from the register file; only a 0->1 transition starts a job.
REQ-007 I_SEQ_WIDTH  input  DIM_W  source image width in pixels.
REQ-008 I_SEQ_HEIGHT  input  DIM_W  source image height in pixels.
REQ-009 I_SEQ_INTR_MASK  input  1  global interrupt mask.
REQ-010 I_SEQ_BEF_MASK  input  1  suppresses setting of the raw done status.
REQ-011 I_SEQ_AFT_MASK  input  1  gates the interrupt output after the status.
REQ-012 I_SEQ_INTR_CLEAR  input  1  clears the raw done status.
REQ-013 I_SEQ_DMA_ACK  input  1  DMA accepted the current request.
REQ-014 I_SEQ_DMA_DONE  input  1  one-cycle pulse: the accepted transfer is complete.
REQ-015 O_SEQ_DMA_REQ  output  1  transfer request to the DMA.
REQ-016 O_SEQ_DMA_WRITE  output  1  direction of the request: 0 = read tile, 1 = write tile.
REQ-017 O_SEQ_TILE_X, O_SEQ_TILE_Y  output  DIM_W-TILE_LOG2 each  current tile column and row, to core_set.
REQ-018 O_SEQ_BUSY  output  1  high while a job is in progress.
REQ-019 O_SEQ_STATUS_DONE  output  1  raw done status, to the register file.
REQ-020 O_SEQ_INTR_DONE  output  1  done interrupt.

Function
REQ-021 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, DONE.
REQ-022 IDLE->RD_REQ on a detected START rise when WIDTH and HEIGHT are both nonzero; BUSY is asserted in the cycle after the detecting edge.
REQ-023 On the START rise, TX_MAX = ceil(WIDTH/2^TILE_LOG2)-1 and TY_MAX = ceil(HEIGHT/2^TILE_LOG2)-1 are latched; TILE_X and TILE_Y are cleared to 0.
REQ-024 Changes to WIDTH or HEIGHT during a job are ignored.
REQ-025 START rise with WIDTH==0 or HEIGHT==0: IDLE->DONE, no DMA request is issued.
REQ-026 RD_REQ: REQ=1, WRITE=0; move to RD_WAIT on the edge where ACK=1.
REQ-027 REQ stays asserted and WRITE stays stable until ACK is sampled high.
REQ-028 RD_WAIT: REQ=0; move to WR_REQ on DONE=1.
REQ-029 WR_REQ/WR_WAIT: same as RD_REQ/RD_WAIT but WRITE=1; on DONE go to NEXT.
REQ-030 DONE or ACK pulses arriving in the REQ state without an ACK, or in IDLE/NEXT/DONE, are ignored.
REQ-031 NEXT, one cycle: tiles advance in raster order.
 - X<TX_MAX: X+1, then RD_REQ.
 - else if Y<TY_MAX: X=0, Y+1, then RD_REQ.
 - else: DONE.
REQ-032 DONE, one cycle: set STATUS_DONE unless BEF_MASK=1; clear BUSY; go to IDLE.
REQ-033 INTR_DONE = STATUS_DONE & ~AFT_MASK & ~INTR_MASK, combinational from registered terms.
REQ-034 INTR_CLEAR clears STATUS_DONE; if it coincides with a set, the set wins.
REQ-035 A START rise while BUSY is ignored; edge detection keeps running so a held level does not restart the job.
REQ-036 Tile coordinates stay constant from RD_REQ through WR_WAIT of each tile.

Reset
REQ-037 HRESET_N low sets, asynchronously:
 - state IDLE;
 - REQ, WRITE, BUSY, STATUS_DONE, INTR_DONE = 0;
 - TILE_X, TILE_Y, TX_MAX, TY_MAX = 0;
 - START edge register = 0.
REQ-038 Soft reset sets the same values on the next edge from any state, including mid-handshake, and overrides START and DONE in the same cycle.

Structure
REQ-039 The FSM state encoding and the TILE_LOG2 default are in the shared rotation package, shared with core_set and dma.
REQ-040 One sub-module, rot_seq_tilecnt, holds the X/Y counters, the max latches and the last-tile flag.

Verification
REQ-041 W=8, H=4, ACK after 2 cycles, DONE after 5 -> two tiles, request sequence RD(0,0), WR(0,0), RD(1,0), WR(1,0); STATUS=1, INTR=1, BUSY drops after the last DONE.
REQ-042 W=5, H=5 -> TX_MAX=1, TY_MAX=1; four tiles in order (0,0),(1,0),(0,1),(1,1); 8 requests.
REQ-043 START held high through the job, then re-pulsed while BUSY -> no second job; a fresh rise after IDLE starts one.
REQ-044 Soft reset during RD_WAIT of tile (1,0) -> next cycle IDLE, REQ=0, coordinates 0, STATUS=0; a late DONE pulse is ignored.
REQ-045 Masks and clear:
 - BEF_MASK=1 -> STATUS stays 0;
 - AFT_MASK=1 -> STATUS=1, INTR=0;
 - INTR_CLEAR coinciding with DONE -> STATUS=1.
REQ-046 W=0, H=16 -> BUSY for one cycle, no REQ, STATUS=1; hard reset mid-job -> all outputs 0 immediately.

Source files
------------

// File: rtl/rot_seq_pkg.sv
// Shared rotation-engine definitions: tile geometry default and the
// sequencer state encoding seen by core_set and dma.
package rot_seq_pkg;

  localparam int ROT_TILE_LOG2 = 2;   // 4x4 pixel tiles
  localparam int ROT_DIM_W     = 16;  // image dimension width

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_RD_REQ  = 3'd1,
    SEQ_RD_WAIT = 3'd2,
    SEQ_WR_REQ  = 3'd3,
    SEQ_WR_WAIT = 3'd4,
    SEQ_NEXT    = 3'd5,
    SEQ_DONE    = 3'd6
  } seq_state_t;

  // A DMA request is pending in either request state.
  function automatic logic is_req_state(seq_state_t s);
    return (s == SEQ_RD_REQ) || (s == SEQ_WR_REQ);
  endfunction

  // The write half of each tile covers its request and its wait.
  function automatic logic is_write_state(seq_state_t s);
    return (s == SEQ_WR_REQ) || (s == SEQ_WR_WAIT);
  endfunction

endpackage

// File: rtl/rot_seq_if.sv
// Register-file / DMA / core_set facing signals of the rotation sequencer.
// slave is the sequencer's view, master the view of whatever drives it.
interface rot_seq_if
  import rot_seq_pkg::*;
#(
  parameter int DIM_W     = ROT_DIM_W,
  parameter int TILE_LOG2 = ROT_TILE_LOG2
);
  localparam int TW = DIM_W - TILE_LOG2;

  logic             I_SEQ_RESET;
  logic             I_SEQ_START;
  logic [DIM_W-1:0] I_SEQ_WIDTH;
  logic [DIM_W-1:0] I_SEQ_HEIGHT;
  logic             I_SEQ_INTR_MASK;
  logic             I_SEQ_BEF_MASK;
  logic             I_SEQ_AFT_MASK;
  logic             I_SEQ_INTR_CLEAR;
  logic             I_SEQ_DMA_ACK;
  logic             I_SEQ_DMA_DONE;
  logic             O_SEQ_DMA_REQ;
  logic             O_SEQ_DMA_WRITE;
  logic [TW-1:0]    O_SEQ_TILE_X;
  logic [TW-1:0]    O_SEQ_TILE_Y;
  logic             O_SEQ_BUSY;
  logic             O_SEQ_STATUS_DONE;
  logic             O_SEQ_INTR_DONE;

  modport slave (
    input  I_SEQ_RESET, I_SEQ_START, I_SEQ_WIDTH, I_SEQ_HEIGHT,
           I_SEQ_INTR_MASK, I_SEQ_BEF_MASK, I_SEQ_AFT_MASK, I_SEQ_INTR_CLEAR,
           I_SEQ_DMA_ACK, I_SEQ_DMA_DONE,
    output O_SEQ_DMA_REQ, O_SEQ_DMA_WRITE, O_SEQ_TILE_X, O_SEQ_TILE_Y,
           O_SEQ_BUSY, O_SEQ_STATUS_DONE, O_SEQ_INTR_DONE
  );

  modport master (
    output I_SEQ_RESET, I_SEQ_START, I_SEQ_WIDTH, I_SEQ_HEIGHT,
           I_SEQ_INTR_MASK, I_SEQ_BEF_MASK, I_SEQ_AFT_MASK, I_SEQ_INTR_CLEAR,
           I_SEQ_DMA_ACK, I_SEQ_DMA_DONE,
    input  O_SEQ_DMA_REQ, O_SEQ_DMA_WRITE, O_SEQ_TILE_X, O_SEQ_TILE_Y,
           O_SEQ_BUSY, O_SEQ_STATUS_DONE, O_SEQ_INTR_DONE
  );

endinterface

// File: rtl/rot_seq_tilecnt.sv
// Raster-order tile counter: latches the last tile column/row at job start
// and walks X then Y one step per advance pulse.
module rot_seq_tilecnt
  import rot_seq_pkg::*;
#(
  parameter int DIM_W     = ROT_DIM_W,
  parameter int TILE_LOG2 = ROT_TILE_LOG2,
  localparam int TW       = DIM_W - TILE_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_rst,
  input  logic             load,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             advance,
  output logic [TW-1:0]    tile_x,
  output logic [TW-1:0]    tile_y,
  output logic             last_tile
);

  logic [TW-1:0]    tx_max, ty_max;
  logic [DIM_W-1:0] width_m1, height_m1;

  // ceil(d / 2^T) - 1 == (d - 1) >> T for any nonzero d; a zero dimension
  // never reaches the counters because the job goes straight to DONE.
  assign width_m1  = width  - DIM_W'(1);
  assign height_m1 = height - DIM_W'(1);
  assign last_tile = (tile_x == tx_max) && (tile_y == ty_max);

  // Max latches and X/Y counters; dimensions are sampled only on load so
  // register-file writes during a job have no effect.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_max <= '0;
      ty_max <= '0;
      tile_x <= '0;
      tile_y <= '0;
    end else if (soft_rst) begin
      tx_max <= '0;
      ty_max <= '0;
      tile_x <= '0;
      tile_y <= '0;
    end else if (load) begin
      tx_max <= TW'(width_m1  >> TILE_LOG2);
      ty_max <= TW'(height_m1 >> TILE_LOG2);
      tile_x <= '0;
      tile_y <= '0;
    end else if (advance) begin
      if (tile_x < tx_max) begin
        tile_x <= tile_x + TW'(1);
      end else if (tile_y < ty_max) begin
        tile_x <= '0;
        tile_y <= tile_y + TW'(1);
      end
    end
  end

endmodule

// File: rtl/rot_seq.sv
// Rotation tile sequencer: for each tile in raster order issues a DMA read
// then a DMA write, then raises the done status / interrupt.
module rot_seq
  import rot_seq_pkg::*;
#(
  parameter int TILE_LOG2 = ROT_TILE_LOG2,
  parameter int DIM_W     = ROT_DIM_W
) (
  input  logic   I_SEQ_HCLK,
  input  logic   I_SEQ_HRESET_N,
  rot_seq_if.slave sif
);

  localparam int TW = DIM_W - TILE_LOG2;

  seq_state_t    state, state_nxt;
  logic          soft_rst;
  logic          start_q, start_rise;
  logic          dims_ok, load, advance, last_tile;
  logic          status_done;
  logic [TW-1:0] tile_x, tile_y;

  assign soft_rst   = sif.I_SEQ_RESET;
  assign start_rise = sif.I_SEQ_START & ~start_q;
  assign dims_ok    = (|sif.I_SEQ_WIDTH) & (|sif.I_SEQ_HEIGHT);
  assign load       = (state == SEQ_IDLE) & start_rise & ~soft_rst;
  assign advance    = (state == SEQ_NEXT);

  // START edge register runs in every state so a level held across a job
  // cannot look like a fresh rise once the sequencer is idle again.
  always_ff @(posedge I_SEQ_HCLK or negedge I_SEQ_HRESET_N) begin
    if (!I_SEQ_HRESET_N) start_q <= 1'b0;
    else if (soft_rst)   start_q <= 1'b0;
    else                 start_q <= sif.I_SEQ_START;
  end

  // State register.
  always_ff @(posedge I_SEQ_HCLK or negedge I_SEQ_HRESET_N) begin
    if (!I_SEQ_HRESET_N) state <= SEQ_IDLE;
    else if (soft_rst)   state <= SEQ_IDLE;
    else                 state <= state_nxt;
  end

  // Next-state logic; ACK/DONE are only looked at in the states that wait
  // for them, so stray pulses elsewhere fall through.
  // NOTE: state_nxt gets its default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SEQ_IDLE:    if (start_rise) state_nxt = dims_ok ? SEQ_RD_REQ : SEQ_DONE;
      SEQ_RD_REQ:  if (sif.I_SEQ_DMA_ACK)  state_nxt = SEQ_RD_WAIT;
      SEQ_RD_WAIT: if (sif.I_SEQ_DMA_DONE) state_nxt = SEQ_WR_REQ;
      SEQ_WR_REQ:  if (sif.I_SEQ_DMA_ACK)  state_nxt = SEQ_WR_WAIT;
      SEQ_WR_WAIT: if (sif.I_SEQ_DMA_DONE) state_nxt = SEQ_NEXT;
      SEQ_NEXT:    state_nxt = last_tile ? SEQ_DONE : SEQ_RD_REQ;
      SEQ_DONE:    state_nxt = SEQ_IDLE;
      default:     state_nxt = SEQ_IDLE;
    endcase
  end

  // Raw done status: a set from DONE beats a coincident clear.
  always_ff @(posedge I_SEQ_HCLK or negedge I_SEQ_HRESET_N) begin
    if (!I_SEQ_HRESET_N)                                  status_done <= 1'b0;
    else if (soft_rst)                                    status_done <= 1'b0;
    else if ((state == SEQ_DONE) && !sif.I_SEQ_BEF_MASK)  status_done <= 1'b1;
    else if (sif.I_SEQ_INTR_CLEAR)                        status_done <= 1'b0;
  end

  rot_seq_tilecnt #(
    .DIM_W     (DIM_W),
    .TILE_LOG2 (TILE_LOG2)
  ) u_tilecnt (
    .clk       (I_SEQ_HCLK),
    .rst_n     (I_SEQ_HRESET_N),
    .soft_rst  (soft_rst),
    .load      (load),
    .width     (sif.I_SEQ_WIDTH),
    .height    (sif.I_SEQ_HEIGHT),
    .advance   (advance),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .last_tile (last_tile)
  );

  // Outputs decode directly from registered state, so they are glitch-free
  // and drop to zero the moment either reset takes hold.
  assign sif.O_SEQ_DMA_REQ     = is_req_state(state);
  assign sif.O_SEQ_DMA_WRITE   = is_write_state(state);
  assign sif.O_SEQ_BUSY        = (state != SEQ_IDLE);
  assign sif.O_SEQ_TILE_X      = tile_x;
  assign sif.O_SEQ_TILE_Y      = tile_y;
  assign sif.O_SEQ_STATUS_DONE = status_done;
  assign sif.O_SEQ_INTR_DONE   = status_done & ~sif.I_SEQ_AFT_MASK & ~sif.I_SEQ_INTR_MASK;

endmodule

// File: tb/tb_rot_seq.sv
// Self-checking bench for rot_seq: a DMA responder pops expected requests
// from a scoreboard queue filled when each job is launched.
module tb_rot_seq;
  import rot_seq_pkg::*;

  localparam int DIM_W    = ROT_DIM_W;
  localparam int TL       = ROT_TILE_LOG2;
  localparam int TW       = DIM_W - TL;
  localparam int ACK_DLY  = 2;
  localparam int DONE_DLY = 5;

  typedef struct packed {
    logic          wr;
    logic [TW-1:0] x;
    logic [TW-1:0] y;
  } req_t;

  typedef struct {
    int w;
    int h;
    bit bef;
    bit aft;
    bit imask;
    bit exp_status;
    bit exp_intr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  req_t exp_q[$];
  vec_t vecs[7];

  rot_seq_if sif ();

  rot_seq dut (
    .I_SEQ_HCLK     (clk),
    .I_SEQ_HRESET_N (rst_n),
    .sif            (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard model: raster order, read then write per tile.
  task automatic push_job(input int w, input int h);
    int nx, ny;
    if (w == 0 || h == 0) return;
    nx = (w + (1 << TL) - 1) / (1 << TL);
    ny = (h + (1 << TL) - 1) / (1 << TL);
    for (int y = 0; y < ny; y++) begin
      for (int x = 0; x < nx; x++) begin
        exp_q.push_back('{wr: 1'b0, x: TW'(x), y: TW'(y)});
        exp_q.push_back('{wr: 1'b1, x: TW'(x), y: TW'(y)});
      end
    end
  endtask

  task automatic idle_check(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      check_bit({name, "_busy"}, sif.O_SEQ_BUSY, 1'b0);
      check_bit({name, "_req"}, sif.O_SEQ_DMA_REQ, 1'b0);
    end
  endtask

  // DMA responder. Called on the negedge a START rise was driven. Returns
  // when BUSY falls, or right after driving the stop_acks-th ACK.
  task automatic serve(input int stop_acks, input bit repulse, input bit hold_start);
    int   cyc = 0;
    int   cnt = 0;
    int   acks = 0;
    bit   in_req = 0;
    bit   in_xfer = 0;
    bit   ended = 0;
    req_t cur = '0;
    while (!ended && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      sif.I_SEQ_DMA_ACK  = 1'b0;
      sif.I_SEQ_DMA_DONE = 1'b0;
      if (cyc == 1) begin
        check_bit("busy_after_start", sif.O_SEQ_BUSY, 1'b1);
        sif.I_SEQ_WIDTH  = DIM_W'($urandom);
        sif.I_SEQ_HEIGHT = DIM_W'($urandom);
        if (!hold_start) sif.I_SEQ_START = 1'b0;
      end
      if (repulse && cyc == 4) sif.I_SEQ_START = 1'b1;
      if (repulse && cyc == 6) sif.I_SEQ_START = 1'b0;
      if (cyc > 1 && !sif.O_SEQ_BUSY) begin
        ended = 1;
      end else if (in_xfer) begin
        check("x_hold_wait", 32'(sif.O_SEQ_TILE_X), 32'(cur.x));
        check("y_hold_wait", 32'(sif.O_SEQ_TILE_Y), 32'(cur.y));
        cnt++;
        if (cnt >= DONE_DLY) begin
          sif.I_SEQ_DMA_DONE = 1'b1;
          in_xfer = 0;
        end
      end else if (in_req || sif.O_SEQ_DMA_REQ) begin
        if (!in_req) begin
          in_req = 1;
          cnt = 0;
          check_bit("req_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_bit("req_write", sif.O_SEQ_DMA_WRITE, cur.wr);
            check("req_x", 32'(sif.O_SEQ_TILE_X), 32'(cur.x));
            check("req_y", 32'(sif.O_SEQ_TILE_Y), 32'(cur.y));
          end
        end else begin
          check_bit("req_held", sif.O_SEQ_DMA_REQ, 1'b1);
          check_bit("write_stable", sif.O_SEQ_DMA_WRITE, cur.wr);
        end
        cnt++;
        if (cnt >= ACK_DLY) begin
          sif.I_SEQ_DMA_ACK = 1'b1;
          in_req = 0;
          in_xfer = 1;
          cnt = 0;
          acks++;
          if (acks == stop_acks) return;
        end
      end
    end
    check_bit("job_end_in_budget", ended, 1'b1);
  endtask

  task automatic run_job(input int w, input int h, input bit bef, input bit aft,
                         input bit imask, input bit pre_clear, input bit hold_start,
                         input bit repulse);
    sif.I_SEQ_BEF_MASK  = bef;
    sif.I_SEQ_AFT_MASK  = aft;
    sif.I_SEQ_INTR_MASK = imask;
    if (pre_clear) begin
      @(negedge clk);
      sif.I_SEQ_INTR_CLEAR = 1'b1;
      @(negedge clk);
      sif.I_SEQ_INTR_CLEAR = 1'b0;
      check_bit("pre_clear_status", sif.O_SEQ_STATUS_DONE, 1'b0);
    end
    push_job(w, h);
    @(negedge clk);
    sif.I_SEQ_WIDTH  = DIM_W'(w);
    sif.I_SEQ_HEIGHT = DIM_W'(h);
    sif.I_SEQ_START  = 1'b1;
    serve(-1, repulse, hold_start);
    check("reqs_left", exp_q.size(), 0);
    check_bit("end_req", sif.O_SEQ_DMA_REQ, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check_bit({name, "_req"}, sif.O_SEQ_DMA_REQ, 1'b0);
    check_bit({name, "_write"}, sif.O_SEQ_DMA_WRITE, 1'b0);
    check_bit({name, "_busy"}, sif.O_SEQ_BUSY, 1'b0);
    check_bit({name, "_status"}, sif.O_SEQ_STATUS_DONE, 1'b0);
    check_bit({name, "_intr"}, sif.O_SEQ_INTR_DONE, 1'b0);
    check({name, "_x"}, 32'(sif.O_SEQ_TILE_X), 32'd0);
    check({name, "_y"}, 32'(sif.O_SEQ_TILE_Y), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            w   h  bef aft imask status intr
    vecs[0] = '{  8,  4, 0,  0,  0,    1,     1 };
    vecs[1] = '{  5,  5, 0,  0,  0,    1,     1 };
    vecs[2] = '{  4,  4, 1,  0,  0,    0,     0 };
    vecs[3] = '{  3,  9, 0,  1,  0,    1,     0 };
    vecs[4] = '{ 16,  1, 0,  0,  1,    1,     0 };
    vecs[5] = '{  0, 16, 0,  0,  0,    1,     1 };
    vecs[6] = '{  7,  0, 0,  0,  0,    1,     1 };

    rst_n = 1'b0;
    sif.I_SEQ_RESET      = 1'b0;
    sif.I_SEQ_START      = 1'b0;
    sif.I_SEQ_WIDTH      = '0;
    sif.I_SEQ_HEIGHT     = '0;
    sif.I_SEQ_INTR_MASK  = 1'b0;
    sif.I_SEQ_BEF_MASK   = 1'b0;
    sif.I_SEQ_AFT_MASK   = 1'b0;
    sif.I_SEQ_INTR_CLEAR = 1'b0;
    sif.I_SEQ_DMA_ACK    = 1'b0;
    sif.I_SEQ_DMA_DONE   = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Table-driven jobs.
    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].w, vecs[i].h, vecs[i].bef, vecs[i].aft, vecs[i].imask, 1'b1, 1'b0, 1'b0);
      check_bit($sformatf("vec%0d_status", i), sif.O_SEQ_STATUS_DONE, vecs[i].exp_status);
      check_bit($sformatf("vec%0d_intr", i), sif.O_SEQ_INTR_DONE, vecs[i].exp_intr);
    end

    // START held high through a job: no restart once idle.
    run_job(8, 4, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle_check("held_start", 4);
    sif.I_SEQ_START = 1'b0;
    // START re-pulsed while busy: exactly one job's worth of requests.
    run_job(8, 4, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle_check("repulse", 4);
    check_bit("repulse_status", sif.O_SEQ_STATUS_DONE, 1'b1);

    // Soft reset in RD_WAIT of tile (1,0) with DONE in the same cycle.
    push_job(8, 4);
    @(negedge clk);
    sif.I_SEQ_WIDTH  = DIM_W'(8);
    sif.I_SEQ_HEIGHT = DIM_W'(4);
    sif.I_SEQ_START  = 1'b1;
    serve(3, 1'b0, 1'b0);
    @(negedge clk);
    sif.I_SEQ_DMA_ACK = 1'b0;
    check("soft_x_before", 32'(sif.O_SEQ_TILE_X), 32'd1);
    sif.I_SEQ_RESET    = 1'b1;
    sif.I_SEQ_DMA_DONE = 1'b1;
    @(negedge clk);
    check_all_zero("soft_reset");
    sif.I_SEQ_RESET    = 1'b0;
    sif.I_SEQ_DMA_DONE = 1'b0;
    @(negedge clk);
    sif.I_SEQ_DMA_DONE = 1'b1;
    @(negedge clk);
    sif.I_SEQ_DMA_DONE = 1'b0;
    idle_check("late_done", 3);
    exp_q.delete();

    // Zero width: one BUSY cycle, no request; clear coinciding with DONE.
    @(negedge clk);
    sif.I_SEQ_INTR_CLEAR = 1'b1;
    @(negedge clk);
    sif.I_SEQ_INTR_CLEAR = 1'b0;
    sif.I_SEQ_WIDTH  = DIM_W'(0);
    sif.I_SEQ_HEIGHT = DIM_W'(16);
    sif.I_SEQ_START  = 1'b1;
    @(negedge clk);
    check_bit("zero_w_busy", sif.O_SEQ_BUSY, 1'b1);
    check_bit("zero_w_req", sif.O_SEQ_DMA_REQ, 1'b0);
    sif.I_SEQ_START      = 1'b0;
    sif.I_SEQ_INTR_CLEAR = 1'b1;
    @(negedge clk);
    check_bit("set_beats_clear_busy", sif.O_SEQ_BUSY, 1'b0);
    check_bit("set_beats_clear_status", sif.O_SEQ_STATUS_DONE, 1'b1);
    check_bit("set_beats_clear_intr", sif.O_SEQ_INTR_DONE, 1'b1);
    @(negedge clk);
    check_bit("clear_alone_status", sif.O_SEQ_STATUS_DONE, 1'b0);
    sif.I_SEQ_INTR_CLEAR = 1'b0;

    // Hard reset mid-job, away from any clock edge.
    run_job(4, 4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    push_job(8, 8);
    @(negedge clk);
    sif.I_SEQ_WIDTH  = DIM_W'(8);
    sif.I_SEQ_HEIGHT = DIM_W'(8);
    sif.I_SEQ_START  = 1'b1;
    serve(2, 1'b0, 1'b0);
    @(negedge clk);
    sif.I_SEQ_DMA_ACK = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("hard_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("hard_reset_release");

    // Recovery job after hard reset.
    run_job(4, 8, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_bit("recover_status", sif.O_SEQ_STATUS_DONE, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
